// File: rtl/css_mcu0_el2_pkg.sv
// Shared EL2 types for the LSU trigger path: trigger configuration and M-stage packet.
package css_mcu0_el2_pkg;

    typedef struct packed {
        logic        select;  // 0: compare address, 1: compare store data
        logic        match;   // 0: exact, 1: NAPOT-style masked compare
        logic        store;
        logic        load;
        logic        m;
        logic [31:0] tdata2;
    } el2_trigger_pkt_t;

    typedef struct packed {
        logic valid;
        logic load;
        logic store;
        logic dma;
        logic half;
        logic word;
    } el2_lsu_pkt_t;

    // A byte access is one with neither half nor word set.
    function automatic logic [31:0] store_data_sized(el2_lsu_pkt_t pkt, logic [31:0] data);
        if (pkt.word) return data;
        if (pkt.half) return {16'h0, data[15:0]};
        return {24'h0, data[7:0]};
    endfunction

endpackage

// File: rtl/css_mcu0_rvmaskandmatch.sv
// Exact or masked compare: with masken set, bit i is ignored when every mask bit below i is one.
module css_mcu0_rvmaskandmatch #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] mask,
    input  logic [WIDTH-1:0] data,
    input  logic             masken,
    output logic             match
);

    logic [WIDTH-1:0] ones_below;
    logic [WIDTH-1:0] bit_ok;

    assign ones_below[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i < WIDTH - 1) begin : g_run
            assign ones_below[i+1] = ones_below[i] & mask[i];
        end
        assign bit_ok[i] = (masken & ones_below[i]) | (mask[i] == data[i]);
    end

    assign match = &bit_ok;

endmodule

// File: rtl/css_mcu0_el2_lsu_trigger_seq.sv
// LSU data/address triggers with optional pair chaining, per-trigger hit thresholds,
// a registered one-cycle fire pulse and sticky hit status.
module css_mcu0_el2_lsu_trigger_seq
    import css_mcu0_el2_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int CNT_W    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  el2_trigger_pkt_t [NUM_TRIG-1:0]  trigger_pkt_any,
    input  logic [NUM_TRIG-1:0]              trig_chain,
    input  logic [NUM_TRIG-1:0][CNT_W-1:0]   trig_count,
    input  logic [NUM_TRIG-1:0]              trig_hit_clr,
    input  el2_lsu_pkt_t                     lsu_pkt_m,
    input  logic                             lsu_flush_m,
    input  logic [31:0]                      lsu_addr_m,
    input  logic [31:0]                      store_data_m,
    output logic [NUM_TRIG-1:0]              lsu_trigger_match_r,
    output logic [NUM_TRIG-1:0]              trig_hit_sticky,
    output logic [NUM_TRIG-1:0][CNT_W-1:0]   trig_cnt
);

    localparam int NUM_PAIR = NUM_TRIG / 2;

    logic                            trig_en;
    logic                            access_ok;
    logic [31:0]                     addr_g;
    logic [31:0]                     data_g;
    logic [NUM_TRIG-1:0]             m_vec;
    logic [NUM_TRIG-1:0]             cmp_hit;
    logic [NUM_TRIG-1:0]             raw;
    logic [NUM_TRIG-1:0]             event_v;
    logic [NUM_TRIG-1:0]             fire_cnt;
    logic [NUM_TRIG-1:0]             fire;
    logic [NUM_TRIG-1:0][CNT_W:0]    cnt_inc;
    logic [NUM_TRIG-1:0][CNT_W-1:0]  cnt_nxt;
    logic [NUM_PAIR-1:0]             chain_odd_unused;

    assign trig_en   = |m_vec;
    assign addr_g    = trig_en ? lsu_addr_m : '0;
    assign data_g    = trig_en ? store_data_sized(lsu_pkt_m, store_data_m) : '0;
    assign access_ok = lsu_pkt_m.valid & ~lsu_pkt_m.dma & ~lsu_flush_m & trig_en;

    for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
        el2_trigger_pkt_t pkt;
        logic [31:0]      operand;
        logic [CNT_W:0]   thresh;

        assign pkt      = trigger_pkt_any[i];
        assign m_vec[i] = pkt.m;
        assign operand  = ~pkt.select ? addr_g : (pkt.store ? data_g : '0);

        css_mcu0_rvmaskandmatch #(.WIDTH(32)) u_match (
            .mask   (pkt.tdata2),
            .data   (operand),
            .masken (pkt.match),
            .match  (cmp_hit[i])
        );

        assign raw[i] = access_ok & cmp_hit[i] &
                        ((lsu_pkt_m.store & pkt.store) | (lsu_pkt_m.load & pkt.load & ~pkt.select));

        // A threshold of zero behaves as one; the extra bit keeps the compare wrap-free.
        assign thresh      = (trig_count[i] == '0) ? (CNT_W+1)'(1) : {1'b0, trig_count[i]};
        assign cnt_inc[i]  = {1'b0, trig_cnt[i]} + (CNT_W+1)'(1);
        assign fire_cnt[i] = event_v[i] & (cnt_inc[i] >= thresh);
    end

    for (genvar p = 0; p < NUM_PAIR; p++) begin : g_pair
        assign chain_odd_unused[p] = trig_chain[2*p+1];
    end

    // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        event_v = raw;
        for (int p = 0; p < NUM_PAIR; p++) begin
            if (trig_chain[2*p]) begin
                event_v[2*p]   = raw[2*p] & raw[2*p+1];
                event_v[2*p+1] = 1'b0;
            end
        end
    end

    always_comb begin
        fire = fire_cnt;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (fire_cnt[i])     cnt_nxt[i] = '0;
            else if (event_v[i]) cnt_nxt[i] = cnt_inc[i][CNT_W-1:0];
            else                 cnt_nxt[i] = trig_cnt[i];
        end
        // The even counter of a chained pair drives both fire bits; the odd one parks at zero.
        for (int p = 0; p < NUM_PAIR; p++) begin
            if (trig_chain[2*p]) begin
                fire[2*p+1]    = fire_cnt[2*p];
                cnt_nxt[2*p+1] = '0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_trigger_match_r <= '0;
            trig_hit_sticky     <= '0;
            trig_cnt            <= '0;
        end else begin
            lsu_trigger_match_r <= fire;
            trig_hit_sticky     <= (trig_hit_sticky & ~trig_hit_clr) | fire;
            trig_cnt            <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_css_mcu0_el2_lsu_trigger_seq.sv
// Scoreboard bench: each access pushes its expected fire vector, a negedge monitor pops and compares.
module tb_css_mcu0_el2_lsu_trigger_seq;
    import css_mcu0_el2_pkg::*;

    localparam int NT = 4;
    localparam int CW = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    el2_trigger_pkt_t [NT-1:0] trigger_pkt_any;
    logic [NT-1:0]           trig_chain;
    logic [NT-1:0][CW-1:0]   trig_count;
    logic [NT-1:0]           trig_hit_clr;
    el2_lsu_pkt_t            lsu_pkt_m;
    logic                    lsu_flush_m;
    logic [31:0]             lsu_addr_m;
    logic [31:0]             store_data_m;
    logic [NT-1:0]           lsu_trigger_match_r;
    logic [NT-1:0]           trig_hit_sticky;
    logic [NT-1:0][CW-1:0]   trig_cnt;

    css_mcu0_el2_lsu_trigger_seq #(.NUM_TRIG(NT), .CNT_W(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .trigger_pkt_any     (trigger_pkt_any),
        .trig_chain          (trig_chain),
        .trig_count          (trig_count),
        .trig_hit_clr        (trig_hit_clr),
        .lsu_pkt_m           (lsu_pkt_m),
        .lsu_flush_m         (lsu_flush_m),
        .lsu_addr_m          (lsu_addr_m),
        .store_data_m        (store_data_m),
        .lsu_trigger_match_r (lsu_trigger_match_r),
        .trig_hit_sticky     (trig_hit_sticky),
        .trig_cnt            (trig_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [NT-1:0] exp;
        string         name;
    } sb_t;

    sb_t sb_q[$];
    int  cyc    = 0;
    int  errors = 0;
    int  checks = 0;
    bit  sb_on  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cycles with no scoreboard entry due must show no fire.
    always @(negedge clk) begin
        logic [NT-1:0] exp;
        string         nm;
        if (sb_on) begin
            exp = '0;
            nm  = "idle";
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                exp = sb_q[0].exp;
                nm  = sb_q[0].name;
                void'(sb_q.pop_front());
            end
            checks++;
            if (lsu_trigger_match_r !== exp) begin
                errors++;
                $display("FAIL %s cyc=%0d: lsu_trigger_match_r=%b expected %b", nm, cyc, lsu_trigger_match_r, exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_cfg();
        trigger_pkt_any = '0;
        trig_chain      = '0;
        trig_count      = '0;
        trig_hit_clr    = '0;
    endtask

    task automatic set_trig(input int i, input logic sel, input logic mt, input logic st,
                            input logic ld, input logic [31:0] td2, input logic [CW-1:0] thr);
        trigger_pkt_any[i].select = sel;
        trigger_pkt_any[i].match  = mt;
        trigger_pkt_any[i].store  = st;
        trigger_pkt_any[i].load   = ld;
        trigger_pkt_any[i].m      = 1'b1;
        trigger_pkt_any[i].tdata2 = td2;
        trig_count[i]             = thr;
    endtask

    // sz: 0 byte, 1 half, 2 word
    task automatic access(input string name, input logic ld, input logic st, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic flush, input logic dma, input logic [NT-1:0] exp);
        lsu_pkt_m.valid = 1'b1;
        lsu_pkt_m.load  = ld;
        lsu_pkt_m.store = st;
        lsu_pkt_m.dma   = dma;
        lsu_pkt_m.half  = (sz == 2'd1);
        lsu_pkt_m.word  = (sz == 2'd2);
        lsu_flush_m     = flush;
        lsu_addr_m      = addr;
        store_data_m    = data;
        sb_q.push_back('{due: cyc + 1, exp: exp, name: name});
        @(posedge clk);
        #1;
        lsu_pkt_m   = '0;
        lsu_flush_m = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_cfg();
        set_trig(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 8'd1);
        lsu_pkt_m       = '0;
        lsu_pkt_m.valid = 1'b1;
        lsu_pkt_m.load  = 1'b1;
        lsu_pkt_m.word  = 1'b1;
        lsu_addr_m      = 32'h0000_0040;
        do_reset();
        lsu_pkt_m = '0;
        idle(1);
        checks++;
        if (trig_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: trig_cnt=%h expected 0", trig_cnt);
        end
        checks++;
        if (trig_hit_sticky !== '0) begin
            errors++;
            $display("FAIL reset_sticky: trig_hit_sticky=%b expected 0", trig_hit_sticky);
        end
    endtask

    task automatic test_napot();
        do_reset();
        clear_cfg();
        set_trig(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_00FF, 8'd0);
        access("napot_in", 1'b1, 1'b0, 2'd2, 32'h1000_0080, 32'h0, 1'b0, 1'b0, 4'b0001);
        idle(1);
        access("napot_out", 1'b1, 1'b0, 2'd2, 32'h1000_0200, 32'h0, 1'b0, 1'b0, 4'b0000);
        // Bit 8 sits inside the don't-care field of eight trailing ones.
        access("napot_bit_k", 1'b1, 1'b0, 2'd2, 32'h1000_0100, 32'h0, 1'b0, 1'b0, 4'b0001);
        access("napot_store_ignored", 1'b0, 1'b1, 2'd2, 32'h1000_0080, 32'h0, 1'b0, 1'b0, 4'b0000);
        set_trig(0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0080, 8'd0);
        access("exact_miss", 1'b1, 1'b0, 2'd2, 32'h1000_0081, 32'h0, 1'b0, 1'b0, 4'b0000);
        access("exact_hit", 1'b1, 1'b0, 2'd2, 32'h1000_0080, 32'h0, 1'b0, 1'b0, 4'b0001);
        checks++;
        if (trig_hit_sticky !== 4'b0001) begin
            errors++;
            $display("FAIL napot_sticky: trig_hit_sticky=%b expected 0001", trig_hit_sticky);
        end
    endtask

    task automatic test_count();
        logic [CW-1:0] seq [3];
        seq = '{8'd1, 8'd2, 8'd0};
        do_reset();
        clear_cfg();
        set_trig(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 8'd3);
        for (int k = 0; k < 3; k++) begin
            access("count_seq", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF, 1'b0, 1'b0,
                   (k == 2) ? 4'b0010 : 4'b0000);
            checks++;
            if (trig_cnt[1] !== seq[k]) begin
                errors++;
                $display("FAIL count_seq_%0d: trig_cnt[1]=%0d expected %0d", k, trig_cnt[1], seq[k]);
            end
        end
        checks++;
        if (trig_hit_sticky !== 4'b0010) begin
            errors++;
            $display("FAIL count_sticky: trig_hit_sticky=%b expected 0010", trig_hit_sticky);
        end
        access("count_one", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0000);
        idle(2);
        checks++;
        if (trig_cnt[1] !== 8'd1) begin
            errors++;
            $display("FAIL count_hold: trig_cnt[1]=%0d expected 1", trig_cnt[1]);
        end
        trigger_pkt_any[1].m = 1'b0;
        access("count_m_off", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[1] !== 8'd1) begin
            errors++;
            $display("FAIL count_m_off: trig_cnt[1]=%0d expected 1", trig_cnt[1]);
        end
        trigger_pkt_any[1].m = 1'b1;
        access("count_two", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0000);
        trig_count[1] = 8'd1;
        access("count_lowered", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0010);
        checks++;
        if (trig_cnt[1] !== 8'd0) begin
            errors++;
            $display("FAIL count_lowered: trig_cnt[1]=%0d expected 0", trig_cnt[1]);
        end
        trig_count[1] = 8'd0;
        access("count_thr0", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0010);
        access("count_addr_miss", 1'b0, 1'b1, 2'd2, 32'h0000_3004, 32'h0, 1'b0, 1'b0, 4'b0000);
        access("count_load_ignored", 1'b1, 1'b0, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_cfg();
        set_trig(1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3000, 8'd0);
        for (int k = 0; k < 3; k++)
            access("b2b", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0010);
        idle(1);
        // Largest threshold: the counter climbs to 254 and must fire on the 255th event.
        do_reset();
        trig_count[1] = 8'd255;
        for (int k = 0; k < 254; k++)
            access("max_thr", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[1] !== 8'd254) begin
            errors++;
            $display("FAIL max_thr_cnt: trig_cnt[1]=%0d expected 254", trig_cnt[1]);
        end
        access("max_thr_fire", 1'b0, 1'b1, 2'd2, 32'h0000_3000, 32'h0, 1'b0, 1'b0, 4'b0010);
        checks++;
        if (trig_cnt[1] !== 8'd0) begin
            errors++;
            $display("FAIL max_thr_wrap: trig_cnt[1]=%0d expected 0", trig_cnt[1]);
        end
    endtask

    task automatic test_chain();
        do_reset();
        clear_cfg();
        trig_chain = 4'b0001;
        set_trig(0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_2000, 8'd0);
        set_trig(1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_00AB, 8'd0);
        access("chain_hit", 1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'b0011);
        access("chain_addr_miss", 1'b0, 1'b1, 2'd0, 32'h0000_2004, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'b0000);
        access("chain_half_miss", 1'b0, 1'b1, 2'd1, 32'h0000_2000, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'b0000);
        trig_count[0] = 8'd2;
        trig_count[1] = 8'd5;
        access("chain_cnt1", 1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[0] !== 8'd1 || trig_cnt[1] !== 8'd0) begin
            errors++;
            $display("FAIL chain_cnt1: trig_cnt[0]=%0d trig_cnt[1]=%0d expected 1 and 0", trig_cnt[0], trig_cnt[1]);
        end
        access("chain_cnt2", 1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'hFFFF_FFAB, 1'b0, 1'b0, 4'b0011);
        checks++;
        if (trig_cnt[0] !== 8'd0 || trig_cnt[1] !== 8'd0) begin
            errors++;
            $display("FAIL chain_cnt2: trig_cnt[0]=%0d trig_cnt[1]=%0d expected 0 and 0", trig_cnt[0], trig_cnt[1]);
        end
        trig_count = '0;
        trig_chain = 4'b0000;
        access("unchained_data", 1'b0, 1'b1, 2'd0, 32'h0000_2004, 32'h0000_00AB, 1'b0, 1'b0, 4'b0010);
        trig_chain = 4'b0010;
        access("odd_chain_bit", 1'b0, 1'b1, 2'd0, 32'h0000_2000, 32'h0000_0012, 1'b0, 1'b0, 4'b0001);
    endtask

    task automatic test_flush_dma();
        do_reset();
        clear_cfg();
        set_trig(2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0500, 8'd3);
        access("fd_first", 1'b0, 1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 4'b0000);
        access("fd_flush", 1'b0, 1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[2] !== 8'd1) begin
            errors++;
            $display("FAIL fd_flush_cnt: trig_cnt[2]=%0d expected 1", trig_cnt[2]);
        end
        access("fd_dma", 1'b0, 1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b0, 1'b1, 4'b0000);
        checks++;
        if (trig_cnt[2] !== 8'd1) begin
            errors++;
            $display("FAIL fd_dma_cnt: trig_cnt[2]=%0d expected 1", trig_cnt[2]);
        end
        access("fd_second", 1'b0, 1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 4'b0000);
        access("fd_fire", 1'b0, 1'b1, 2'd2, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 4'b0100);
    endtask

    task automatic test_sticky_reset();
        do_reset();
        clear_cfg();
        set_trig(3, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, 8'd1);
        access("sticky_fire", 1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 4'b1000);
        trig_hit_clr = 4'b1000;
        access("sticky_fire_clr", 1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 4'b1000);
        trig_hit_clr = 4'b0000;
        checks++;
        if (trig_hit_sticky !== 4'b1000) begin
            errors++;
            $display("FAIL sticky_fire_clr: trig_hit_sticky=%b expected 1000", trig_hit_sticky);
        end
        trig_hit_clr = 4'b1000;
        idle(1);
        trig_hit_clr = 4'b0000;
        checks++;
        if (trig_hit_sticky !== 4'b0000) begin
            errors++;
            $display("FAIL sticky_clr: trig_hit_sticky=%b expected 0000", trig_hit_sticky);
        end
        trig_count[3] = 8'd3;
        access("rst_cnt1", 1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 4'b0000);
        access("rst_cnt2", 1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[3] !== 8'd2) begin
            errors++;
            $display("FAIL rst_precount: trig_cnt[3]=%0d expected 2", trig_cnt[3]);
        end
        lsu_pkt_m.valid = 1'b1;
        lsu_pkt_m.store = 1'b1;
        lsu_pkt_m.word  = 1'b1;
        lsu_addr_m      = 32'h0000_0600;
        do_reset();
        lsu_pkt_m = '0;
        checks++;
        if (trig_cnt[3] !== 8'd0 || lsu_trigger_match_r !== 4'b0000) begin
            errors++;
            $display("FAIL rst_midcount: trig_cnt[3]=%0d match_r=%b expected 0 and 0000", trig_cnt[3], lsu_trigger_match_r);
        end
        access("rst_after", 1'b0, 1'b1, 2'd2, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (trig_cnt[3] !== 8'd1) begin
            errors++;
            $display("FAIL rst_after_cnt: trig_cnt[3]=%0d expected 1", trig_cnt[3]);
        end
    endtask

    initial begin
        rst          = 1'b1;
        lsu_pkt_m    = '0;
        lsu_flush_m  = 1'b0;
        lsu_addr_m   = '0;
        store_data_m = '0;
        clear_cfg();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        sb_on = 1'b1;

        test_reset();
        test_napot();
        test_count();
        test_back_to_back();
        test_chain();
        test_flush_dma();
        test_sticky_reset();
        idle(2);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        sb_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
